qtree_load_sequencer: RTL

- Front-end controller for the quadtree benchmark kernels (map/kron family).
- Deserialises NUM_INPUTS postfix-serialised QTree streams into heap writes, with a bump allocator and a pointer stack.
- Then launches the kernel by issuing a go token plus one root pointer per input, and captures the kernel's result pointer.
- Replaces the per-kernel hand-written stream/stack/launch logic in the test wrappers.

---
 rtl/qtree_load_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/qtree_load_sequencer.sv
`timescale 1ns/1ps
// QTree stream loader: postfix tokens -> heap writes via pointer stack,
// then kernel launch (go + roots) and result capture.
module qtree_load_sequencer #(
  parameter int PTR_W       = 16,
  parameter int PAYLOAD_W   = 8,
  parameter int STACK_DEPTH = 256,
  parameter int NUM_INPUTS  = 2,
  parameter int HEAP_BASE   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2+PAYLOAD_W-1:0]      s_tdata,
  input  logic                        s_tlast,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  output logic                        hw_valid,
  input  logic                        hw_ready,
  output logic [PTR_W-1:0]            hw_addr,
  output logic [2+4*PTR_W-1:0]        hw_data,
  output logic                        go_valid,
  input  logic                        go_ready,
  output logic [NUM_INPUTS-1:0]       root_valid,
  input  logic [NUM_INPUTS-1:0]       root_ready,
  output logic [NUM_INPUTS*PTR_W-1:0] root_data,
  input  logic                        res_valid,
  output logic                        res_ready,
  input  logic [PTR_W-1:0]            res_data,
  output logic [PTR_W-1:0]            result_data,
  output logic                        done,
  output logic                        error,
  output logic [1:0]                  err_code
);

  localparam int TW  = 2 + PAYLOAD_W;
  localparam int HW  = 2 + 4 * PTR_W;
  localparam int AW  = $clog2(STACK_DEPTH);
  localparam int SPW = AW + 1;
  localparam int KW  = $clog2(NUM_INPUTS + 1);

  typedef enum logic [2:0] {
    LOAD, WRITE, LAUNCH, WAIT_RES, DONE, ERROR
  } state_t;

  state_t state_q, state_d;

  logic [PTR_W-1:0] stack [STACK_DEPTH];
  logic [SPW-1:0]   sp_q;
  logic [PTR_W-1:0] alloc_q;
  logic [KW-1:0]    k_q;
  logic [PTR_W-1:0] hw_addr_q;
  logic [HW-1:0]    hw_data_q;
  logic             last_q;

  logic [NUM_INPUTS-1:0][PTR_W-1:0] roots_q;
  logic                  go_pend_q;
  logic [NUM_INPUTS-1:0] root_pend_q;
  logic [PTR_W-1:0]      result_q;
  logic                  done_q;
  logic                  error_q;
  logic [1:0]            err_code_q;

  logic [1:0]           tag;
  logic [PAYLOAD_W-1:0] payload;
  logic                 is_node;
  logic                 accept;
  logic [SPW-1:0]       post_sp;
  logic [SPW-1:0]       sp_m4;
  logic [AW-1:0]        push_idx;
  logic [3:0][PTR_W-1:0] child;
  logic                 e_under;
  logic                 e_over;
  logic                 e_root;
  logic                 tok_err;
  logic [1:0]           err_c;
  logic [HW-1:0]        wr_data;
  logic                 go_left;
  logic [NUM_INPUTS-1:0] root_left;

  assign tag     = s_tdata[1:0];
  assign payload = s_tdata[TW-1:2];
  assign is_node = (tag == 2'd2);
  assign accept  = (state_q == LOAD) && s_tvalid;
  assign sp_m4   = sp_q - SPW'(4);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      child[i] = stack[AW'(sp_q - SPW'(4 - i))];
    end
  end

  always_comb begin
    post_sp  = is_node ? sp_q - SPW'(3) : sp_q + SPW'(1);
    push_idx = is_node ? sp_m4[AW-1:0] : sp_q[AW-1:0];
    e_under  = is_node && (sp_q < SPW'(4));
    e_over   = (!is_node && (sp_q == SPW'(STACK_DEPTH))) || (&alloc_q);
    e_root   = s_tlast && (post_sp != SPW'(1));
    tok_err  = e_under || e_over || e_root;
    err_c    = 2'd0;
    if (e_under)     err_c = 2'd1;
    else if (e_over) err_c = 2'd2;
    else if (e_root) err_c = 2'd3;
    if (is_node) wr_data = {child[3], child[2], child[1], child[0], tag};
    else         wr_data = HW'({payload, tag});
  end

  assign go_left   = go_pend_q & ~go_ready;
  assign root_left = root_pend_q & ~root_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: begin
        if (accept) state_d = tok_err ? ERROR : WRITE;
      end
      WRITE: begin
        if (hw_ready) begin
          if (last_q && (k_q == KW'(NUM_INPUTS - 1))) state_d = LAUNCH;
          else state_d = LOAD;
        end
      end
      LAUNCH: begin
        if (!go_left && (root_left == '0)) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (res_valid) state_d = DONE;
      end
      DONE:  state_d = DONE;
      ERROR: state_d = ERROR;
      default: state_d = state_q;
    endcase
  end

  // Stack RAM is not reset; only sp defines which entries are live.
  always_ff @(posedge clk) begin
    if (accept && !tok_err) stack[push_idx] <= alloc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      sp_q        <= '0;
      alloc_q     <= PTR_W'(HEAP_BASE);
      k_q         <= '0;
      hw_addr_q   <= '0;
      hw_data_q   <= '0;
      last_q      <= 1'b0;
      roots_q     <= '0;
      go_pend_q   <= 1'b0;
      root_pend_q <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      if (accept && !tok_err) begin
        sp_q      <= post_sp;
        hw_addr_q <= alloc_q;
        hw_data_q <= wr_data;
        last_q    <= s_tlast;
      end
      if (accept && tok_err) begin
        error_q    <= 1'b1;
        err_code_q <= err_c;
      end
      if ((state_q == WRITE) && hw_ready) begin
        alloc_q <= alloc_q + 1'b1;
        if (last_q) begin
          sp_q <= '0;
          k_q  <= k_q + 1'b1;
          for (int i = 0; i < NUM_INPUTS; i++) begin
            if (k_q == KW'(i)) roots_q[i] <= hw_addr_q;
          end
        end
        if (state_d == LAUNCH) begin
          go_pend_q   <= 1'b1;
          root_pend_q <= '1;
        end
      end
      if (state_q == LAUNCH) begin
        go_pend_q   <= go_left;
        root_pend_q <= root_left;
      end
      if ((state_q == WAIT_RES) && res_valid) begin
        result_q <= res_data;
        done_q   <= 1'b1;
      end
    end
  end

  assign s_tready    = (state_q == LOAD);
  assign hw_valid    = (state_q == WRITE);
  assign hw_addr     = hw_addr_q;
  assign hw_data     = hw_data_q;
  assign go_valid    = go_pend_q;
  assign root_valid  = root_pend_q;
  assign root_data   = roots_q;
  assign res_ready   = (state_q == WAIT_RES);
  assign result_data = result_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;

endmodule
